// File: rtl/fetch_stage.sv
// fetch_stage: single-issue instruction fetch with a loadable instruction
// memory, stall/redirect handling and an address-fault halt state.
module fetch_stage #(
  parameter int unsigned DEPTH     = 256,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP       = 32'h0000_0013
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     ld_en,
  input  logic [$clog2(DEPTH)-1:0] ld_addr,
  input  logic [31:0]              ld_data,
  input  logic                     stall,
  input  logic                     redirect,
  input  logic [31:0]              redirect_pc,
  output logic [31:0]              pc_out,
  output logic [31:0]              inst_out,
  output logic                     inst_valid,
  output logic                     fault
);

  localparam int unsigned AW = $clog2(DEPTH);
  // Size of the fetchable window in bytes; one extra bit so DEPTH*4 never wraps.
  localparam logic [32:0] SPAN = 33'(DEPTH) << 2;

  localparam logic [1:0] ST_BOOT = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HALT = 2'd2;

  logic [31:0] r_mem [DEPTH];

  logic [1:0]  r_state;
  logic [31:0] r_fetch_pc;
  logic [31:0] r_pc_out;
  logic [31:0] r_inst;
  logic        r_valid;
  logic        r_fault;

  logic [1:0]    w_state_nxt;
  logic [31:0]   w_fetch_pc_nxt;
  logic [31:0]   w_pc_out_nxt;
  logic [31:0]   w_inst_nxt;
  logic          w_valid_nxt;
  logic          w_fault_nxt;

  logic [31:0]   w_offset;
  logic          w_aligned;
  logic          w_above_base;
  logic          w_below_top;
  logic          w_addr_ok;
  logic [AW-1:0] w_index;
  logic [31:0]   w_rd_data;

  // Address decode of the current fetch PC into a word index plus validity.
  always_comb begin
    w_offset     = r_fetch_pc - BASE_ADDR;
    w_aligned    = (r_fetch_pc[1:0] == 2'b00);
    w_above_base = (r_fetch_pc >= BASE_ADDR);
    w_below_top  = ({1'b0, w_offset} < SPAN);
    w_addr_ok    = w_aligned && w_above_base && w_below_top;
    w_index      = w_offset[AW+1:2];
    w_rd_data    = r_mem[w_index];
  end

  // Program-load port; reads sample the pre-write word on the same edge.
  always_ff @(posedge clk) begin
    if (!reset && ld_en) begin
      r_mem[ld_addr] <= ld_data;
    end
  end

  // Next-state and next-output logic; redirect overrides everything else.
  always_comb begin
    w_state_nxt    = r_state;
    w_fetch_pc_nxt = r_fetch_pc;
    w_pc_out_nxt   = r_pc_out;
    w_inst_nxt     = r_inst;
    w_valid_nxt    = r_valid;
    w_fault_nxt    = r_fault;

    if (redirect) begin
      w_state_nxt    = ST_RUN;
      w_fetch_pc_nxt = redirect_pc;
      w_inst_nxt     = NOP;
      w_valid_nxt    = 1'b0;
      w_fault_nxt    = 1'b0;
    end else begin
      case (r_state)
        ST_BOOT: begin
          w_state_nxt = ST_RUN;
          w_valid_nxt = 1'b0;
        end
        ST_RUN: begin
          if (!stall) begin
            if (w_addr_ok) begin
              w_pc_out_nxt   = r_fetch_pc;
              w_inst_nxt     = w_rd_data;
              w_valid_nxt    = 1'b1;
              w_fetch_pc_nxt = r_fetch_pc + 32'd4;
            end else begin
              // Bad address: park in HALT with the offending PC kept.
              w_state_nxt = ST_HALT;
              w_inst_nxt  = NOP;
              w_valid_nxt = 1'b0;
              w_fault_nxt = 1'b1;
            end
          end
        end
        ST_HALT: begin
          w_valid_nxt = 1'b0;
          w_fault_nxt = 1'b1;
        end
        default: begin
          w_state_nxt = ST_BOOT;
          w_valid_nxt = 1'b0;
        end
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_BOOT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Fetch PC and registered output stage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_fetch_pc <= RESET_PC;
      r_pc_out   <= 32'd0;
      r_inst     <= NOP;
      r_valid    <= 1'b0;
      r_fault    <= 1'b0;
    end else begin
      r_fetch_pc <= w_fetch_pc_nxt;
      r_pc_out   <= w_pc_out_nxt;
      r_inst     <= w_inst_nxt;
      r_valid    <= w_valid_nxt;
      r_fault    <= w_fault_nxt;
    end
  end

  assign pc_out     = r_pc_out;
  assign inst_out   = r_inst;
  assign inst_valid = r_valid;
  assign fault      = r_fault;

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: scoreboard bench for fetch_stage (DEPTH=4) with directed
// scenarios followed by randomized stall/redirect/load/reset traffic.
module tb_fetch_stage;

  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] BASE  = 32'h0000_0000;
  localparam logic [31:0] RPC   = 32'h0000_0000;
  localparam logic [31:0] NOPV  = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic        ld_en;
  logic [1:0]  ld_addr;
  logic [31:0] ld_data;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] pc_out;
  logic [31:0] inst_out;
  logic        inst_valid;
  logic        fault;

  always #5 clk = ~clk;

  fetch_stage #(
    .DEPTH(DEPTH), .BASE_ADDR(BASE), .RESET_PC(RPC), .NOP(NOPV)
  ) dut (
    .clk(clk), .reset(reset), .ld_en(ld_en), .ld_addr(ld_addr),
    .ld_data(ld_data), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .pc_out(pc_out), .inst_out(inst_out),
    .inst_valid(inst_valid), .fault(fault)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        valid;
    logic        fault;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model state: memory, next fetch address, phase flags, outputs.
  logic [31:0] m_mem [DEPTH];
  logic [31:0] m_pc;
  bit          m_boot;
  bit          m_halt;
  exp_t        m_out;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h required %h at %0t", name, act, req, $time);
    end
  endtask

  function automatic bit addr_ok(input logic [31:0] a);
    longint unsigned la;
    la = 64'(a);
    return (a % 4 == 0) && (la >= 64'(BASE)) && (la < 64'(BASE) + 64'(4 * DEPTH));
  endfunction

  task automatic model_reset();
    m_out.pc    = 32'd0;
    m_out.inst  = NOPV;
    m_out.valid = 1'b0;
    m_out.fault = 1'b0;
    m_pc   = RPC;
    m_boot = 1'b1;
    m_halt = 1'b0;
  endtask

  // One clock edge of the model with the inputs that are present at that edge.
  task automatic model_edge(input bit s_stall, input bit s_redir, input logic [31:0] s_rpc,
                            input bit s_ld, input logic [1:0] s_addr, input logic [31:0] s_data);
    if (s_redir) begin
      m_pc        = s_rpc;
      m_out.valid = 1'b0;
      m_out.inst  = NOPV;
      m_out.fault = 1'b0;
      m_boot      = 1'b0;
      m_halt      = 1'b0;
    end else if (m_boot) begin
      m_boot = 1'b0;
    end else if (m_halt || s_stall) begin
      // outputs and fetch address unchanged
    end else if (addr_ok(m_pc)) begin
      m_out.pc    = m_pc;
      m_out.inst  = m_mem[int'((m_pc - BASE) / 4)];
      m_out.valid = 1'b1;
      m_pc        = m_pc + 32'd4;
    end else begin
      m_halt      = 1'b1;
      m_out.fault = 1'b1;
      m_out.valid = 1'b0;
      m_out.inst  = NOPV;
    end
    if (s_ld) m_mem[s_addr] = s_data;
  endtask

  // Drive one cycle of inputs at the falling edge. s_rst: 0 none, 1 held
  // through the rising edge, 2 pulsed and released before the rising edge.
  task automatic step(input bit s_stall, input bit s_redir, input logic [31:0] s_rpc,
                      input bit s_ld, input logic [1:0] s_addr, input logic [31:0] s_data,
                      input int s_rst);
    @(negedge clk);
    stall       = s_stall;
    redirect    = s_redir;
    redirect_pc = s_rpc;
    ld_en       = s_ld;
    ld_addr     = s_addr;
    ld_data     = s_data;
    if (s_rst != 0 && !reset) begin
      reset = 1'b1;
      #1;
      chk("async_rst_pc",    pc_out,             32'd0);
      chk("async_rst_inst",  inst_out,           NOPV);
      chk("async_rst_valid", 32'(inst_valid),    32'd0);
      chk("async_rst_fault", 32'(fault),         32'd0);
    end
    if (s_rst != 0) model_reset();
    if (s_rst == 2) begin
      #1 reset = 1'b0;
    end else begin
      reset = (s_rst == 1);
    end
    if (s_rst != 1) model_edge(s_stall, s_redir, s_rpc, s_ld, s_addr, s_data);
    exp_q.push_back(m_out);
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 32'd0, 1'b0, 2'd0, 32'd0, 0);
  endtask

  task automatic expect_o(input string name, input logic [31:0] pc, input logic [31:0] inst,
                          input bit valid, input bit flt);
    chk({name, "_pc"},    pc_out,          pc);
    chk({name, "_inst"},  inst_out,        inst);
    chk({name, "_valid"}, 32'(inst_valid), 32'(valid));
    chk({name, "_fault"}, 32'(fault),      32'(flt));
  endtask

  // Monitor: compare DUT outputs to the oldest pending expectation after each edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        chk("sb_pc",    pc_out,          e.pc);
        chk("sb_inst",  inst_out,        e.inst);
        chk("sb_valid", 32'(inst_valid), 32'(e.valid));
        chk("sb_fault", 32'(fault),      32'(e.fault));
      end
    end
  end

  // Time bound on the whole run.
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish required finish");
    $fatal(1, "watchdog");
  end

  logic [31:0] words [4];
  logic [31:0] rpc_r;

  initial begin
    words[0] = 32'hAAAA_AAAA;
    words[1] = 32'hBBBB_BBBB;
    words[2] = 32'hCCCC_CCCC;
    words[3] = 32'hDDDD_DDDD;
    for (int i = 0; i < DEPTH; i++) m_mem[i] = 32'hx;
    model_reset();
    reset = 1'b1; ld_en = 1'b0; ld_addr = 2'd0; ld_data = 32'd0;
    stall = 1'b0; redirect = 1'b0; redirect_pc = 32'd0;

    step(1'b0, 1'b0, 32'd0, 1'b0, 2'd0, 32'd0, 1);
    step(1'b0, 1'b0, 32'd0, 1'b0, 2'd0, 32'd0, 1);
    expect_o("reset", 32'd0, NOPV, 1'b0, 1'b0);

    // Load the program while redirect keeps the fetch idle.
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 32'd0, 1'b1, 2'(i), words[i], 0);
    step(1'b0, 1'b0, 32'd0, 1'b0, 2'd0, 32'd0, 1);
    step(1'b0, 1'b0, 32'd0, 1'b0, 2'd0, 32'd0, 0);
    expect_o("boot", 32'd0, NOPV, 1'b0, 1'b0);

    idle(); expect_o("seq0", 32'h0, 32'hAAAA_AAAA, 1'b1, 1'b0);
    idle(); expect_o("seq4", 32'h4, 32'hBBBB_BBBB, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 32'd0, 1'b0, 2'd0, 32'd0, 0);
      expect_o("stall_hold", 32'h4, 32'hBBBB_BBBB, 1'b1, 1'b0);
    end
    idle(); expect_o("seq8", 32'h8, 32'hCCCC_CCCC, 1'b1, 1'b0);
    idle(); expect_o("seqC", 32'hC, 32'hDDDD_DDDD, 1'b1, 1'b0);

    step(1'b1, 1'b1, 32'hC, 1'b0, 2'd0, 32'd0, 0);
    expect_o("redir_stall", 32'hC, NOPV, 1'b0, 1'b0);
    idle(); expect_o("redir_C", 32'hC, 32'hDDDD_DDDD, 1'b1, 1'b0);

    idle(); expect_o("past_end", 32'hC, NOPV, 1'b0, 1'b1);
    step(1'b1, 1'b0, 32'd0, 1'b0, 2'd0, 32'd0, 0);
    step(1'b0, 1'b0, 32'd0, 1'b0, 2'd0, 32'd0, 0);
    step(1'b1, 1'b0, 32'd0, 1'b0, 2'd0, 32'd0, 0);
    expect_o("halt_hold", 32'hC, NOPV, 1'b0, 1'b1);
    step(1'b0, 1'b1, 32'h0, 1'b0, 2'd0, 32'd0, 0);
    expect_o("halt_exit", 32'hC, NOPV, 1'b0, 1'b0);
    idle(); expect_o("restart0", 32'h0, 32'hAAAA_AAAA, 1'b1, 1'b0);

    step(1'b0, 1'b1, 32'h6, 1'b0, 2'd0, 32'd0, 0);
    expect_o("misalign_redir", 32'h0, NOPV, 1'b0, 1'b0);
    idle(); expect_o("misalign_fault", 32'h0, NOPV, 1'b0, 1'b1);

    step(1'b0, 1'b1, 32'h8, 1'b0, 2'd0, 32'd0, 0);
    step(1'b0, 1'b0, 32'd0, 1'b1, 2'd2, 32'h1234_5678, 0);
    expect_o("rdw_old", 32'h8, 32'hCCCC_CCCC, 1'b1, 1'b0);
    step(1'b0, 1'b1, 32'h8, 1'b0, 2'd0, 32'd0, 0);
    idle(); expect_o("rdw_new", 32'h8, 32'h1234_5678, 1'b1, 1'b0);

    step(1'b0, 1'b1, 32'h0, 1'b1, 2'd2, 32'hCCCC_CCCC, 0);
    idle(); idle(); idle();
    expect_o("pre_rst8", 32'h8, 32'hCCCC_CCCC, 1'b1, 1'b0);
    step(1'b0, 1'b0, 32'd0, 1'b0, 2'd0, 32'd0, 2);
    expect_o("post_pulse_boot", 32'd0, NOPV, 1'b0, 1'b0);
    idle(); expect_o("after_pulse0", 32'h0, 32'hAAAA_AAAA, 1'b1, 1'b0);

    // Held reset with a load attempt that must be ignored.
    step(1'b0, 1'b0, 32'd0, 1'b1, 2'd3, 32'hEEEE_EEEE, 1);
    step(1'b0, 1'b0, 32'd0, 1'b0, 2'd0, 32'd0, 0);
    idle(); idle(); idle(); idle();
    expect_o("rst_ld_ignored", 32'hC, 32'hDDDD_DDDD, 1'b1, 1'b0);

    // Randomized traffic.
    for (int n = 0; n < 1500; n++) begin
      case ($urandom_range(0, 7))
        0, 1, 2, 3: rpc_r = 32'($urandom_range(0, 3)) * 32'd4;
        4:          rpc_r = 32'($urandom_range(0, 3)) * 32'd4 + 32'($urandom_range(1, 3));
        5:          rpc_r = 32'h10;
        6:          rpc_r = 32'hFFFF_FFFC;
        default:    rpc_r = $urandom;
      endcase
      step($urandom_range(0, 9) < 3, $urandom_range(0, 9) == 0, rpc_r,
           $urandom_range(0, 4) == 0, 2'($urandom_range(0, 3)), $urandom,
           ($urandom_range(0, 99) == 0) ? 1 : 0);
    end

    @(posedge clk);
    #3;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
